// File: rtl/multicycle_alu.sv
// Multi-cycle 32-bit ALU with valid/ready handshakes; shifts iterate one bit per cycle.
// Define ALU_FAST_SHIFT_EN to replace the iterative shifter with a single-cycle barrel shifter.
module multicycle_alu (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  alu_op,
    input  logic [31:0] alu_in_1,
    input  logic [31:0] alu_in_2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] alu_result,
    output logic        alu_zero
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_SLL = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_SRA = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] result_q, result_d;
    logic        accept;
    logic [4:0]  shamt;

`ifndef ALU_FAST_SHIFT_EN
    logic [31:0] work_q, work_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
`endif

    function automatic logic is_shift(input logic [2:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

    // Single-cycle evaluation; also covers zero-distance shifts in the iterative build.
    function automatic logic [31:0] eval_op(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] r;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_SLL:  r = a << b[4:0];
            OP_XOR:  r = a ^ b;
            OP_OR:   r = a | b;
            OP_AND:  r = a & b;
            OP_SRL:  r = a >> b[4:0];
            default: r = $unsigned($signed(a) >>> b[4:0]);
        endcase
        return r;
    endfunction

`ifndef ALU_FAST_SHIFT_EN
    function automatic logic [31:0] shift_step(input logic [2:0] op, input logic [31:0] w);
        logic [31:0] r;
        case (op)
            OP_SLL:  r = {w[30:0], 1'b0};
            OP_SRL:  r = {1'b0, w[31:1]};
            default: r = {w[31], w[31:1]};
        endcase
        return r;
    endfunction
`endif

    assign accept = in_valid && in_ready;
    assign shamt  = alu_in_2[4:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
`ifndef ALU_FAST_SHIFT_EN
                    if (is_shift(alu_op) && (shamt != 5'd0)) begin
                        state_d = BUSY;
                    end else begin
                        state_d = DONE;
                    end
`else
                    state_d = DONE;
`endif
                end
            end
`ifndef ALU_FAST_SHIFT_EN
            BUSY: begin
                if (cnt_q == 5'd1) begin
                    state_d = DONE;
                end
            end
`endif
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Result register only changes when entering DONE, so partial shifts never reach the output.
    always_comb begin
        result_d = result_q;
`ifndef ALU_FAST_SHIFT_EN
        work_d   = work_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
`ifndef ALU_FAST_SHIFT_EN
                    if (is_shift(alu_op) && (shamt != 5'd0)) begin
                        work_d = alu_in_1;
                        cnt_d  = shamt;
                        op_d   = alu_op;
                    end else begin
                        result_d = eval_op(alu_op, alu_in_1, alu_in_2);
                    end
`else
                    result_d = eval_op(alu_op, alu_in_1, alu_in_2);
`endif
                end
            end
`ifndef ALU_FAST_SHIFT_EN
            BUSY: begin
                work_d = shift_step(op_q, work_q);
                cnt_d  = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    result_d = shift_step(op_q, work_q);
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_q <= 32'd0;
`ifndef ALU_FAST_SHIFT_EN
            work_q   <= 32'd0;
            cnt_q    <= 5'd0;
            op_q     <= 3'd0;
`endif
        end else begin
            result_q <= result_d;
`ifndef ALU_FAST_SHIFT_EN
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
`endif
        end
    end

    assign alu_result = result_q;
    assign alu_zero   = (result_q == 32'd0);

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 SHALL provide: clk  input  1  sole clock, rising edge.
REQ-002 SHALL provide: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL provide: in_valid  input  1  operation request present.
REQ-004 SHALL provide: in_ready  output  1  block can accept a request.
REQ-005 SHALL provide: alu_op  input  3  operation code from the ALU control unit: 000 ADD, 001 SUB, 010 SLL, 011 XOR, 100 OR, 101 AND, 110 SRL, 111 SRA.
REQ-006 SHALL provide: alu_in_1  input  32  first operand / shift source.
REQ-007 SHALL provide: alu_in_2  input  32  second operand; bits [4:0] are the shift amount for shifts.
REQ-008 SHALL provide: out_valid  output  1  result available.
REQ-009 SHALL provide: out_ready  input  1  consumer accepts result.
REQ-010 SHALL provide: alu_result  output  32  registered result.
REQ-011 SHALL provide: alu_zero  output  1  high when alu_result == 0.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, DONE; in_ready high only in IDLE.
REQ-013 SHALL accept a request on a rising edge with in_valid && in_ready, capturing alu_op, both operands and shamt in that cycle; inputs are ignored afterwards.
REQ-014 Non-shift ops (ADD, SUB, XOR, OR, AND) SHALL go IDLE -> DONE with result registered at acceptance: out_valid high the next cycle (latency 1).
REQ-015 ADD/SUB SHALL be 32-bit modulo 2^32, carry/overflow discarded.
REQ-016 Shifts SHALL go IDLE -> BUSY with a 5-bit down-counter loaded with shamt; each BUSY cycle shifts the working register one bit (SLL zero-fill left, SRL zero-fill right, SRA sign-fill right) and decrements the counter.
REQ-017 BUSY -> DONE SHALL occur on the cycle the counter reaches 0; shift latency = shamt + 1 cycles from acceptance to out_valid.
REQ-018 A shift with shamt == 0 SHALL bypass BUSY: latency 1, result equals alu_in_1.
REQ-019 shamt == 31 SHALL complete in 32 cycles; counter SHALL never wrap.
REQ-020 In DONE, out_valid, alu_result and alu_zero SHALL hold stable until out_valid && out_ready on a rising edge, then go to IDLE.
REQ-021 Back-to-back: no new request SHALL be accepted in the cycle the result is consumed; next acceptance earliest the following cycle (in_ready rises in IDLE).
REQ-022 alu_zero SHALL be combinationally derived from registered alu_result.

Reset
REQ-023 Reset low SHALL force IDLE immediately, independent of clk, aborting any operation in progress; no partial result is ever presented.
REQ-024 During and after reset: in_ready = 1, out_valid = 0, alu_result = 0, alu_zero = 1, counter = 0.
REQ-025 First acceptance SHALL be possible on the first rising edge after reset deasserts.

Configuration
REQ-026 Macro ALU_FAST_SHIFT_EN: when defined, shifts SHALL use a single-cycle barrel shifter and follow the REQ-014 path (latency 1, BUSY unused); when undefined, shifts SHALL follow REQ-016..REQ-019 iterative behaviour. Result values SHALL be identical in both builds.

Verification
REQ-027 ADD 0x7FFFFFFF + 0x00000001, out_ready=1 -> out_valid one cycle after acceptance, alu_result 0x80000000, alu_zero 0.
REQ-028 SUB 0x00000005 - 0x00000005 -> alu_result 0x00000000, alu_zero 1, latency 1.
REQ-029 SRA 0x80000000 by 31, macro undefined -> in_ready low for 31 BUSY cycles, out_valid 32 cycles after acceptance, alu_result 0xFFFFFFFF; macro defined -> same value, latency 1.
REQ-030 SLL 0x00000001 by 0 -> latency 1, alu_result 0x00000001, BUSY never entered.
REQ-031 XOR 0xF0F0F0F0 ^ 0xFFFF0000 with out_ready=0 for 5 cycles -> alu_result 0x0F0FF0F0 held stable, in_ready 0, second in_valid ignored until consumption.
REQ-032 SRL 0xFFFFFFFF by 16, reset pulsed low mid-BUSY -> out_valid 0, alu_result 0, in_ready 1 immediately; next request accepted after reset release.
